// File: rtl/ctrl_pipe_unit.sv
// ID-stage control decoder with NZCV condition gating and a PIPE_DEPTH-stage
// control pipeline (EX .. MEM .. WB) supporting hazard bubbles, flush and global stall.
module ctrl_pipe_unit #(
  parameter int PIPE_DEPTH    = 3,
  parameter bit STATUS_BYPASS = 1'b1,
  parameter int CMD_W         = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            opcode,
  input  logic [1:0]            mode,
  input  logic                  s_in,
  input  logic [3:0]            cond,
  input  logic                  id_valid,
  input  logic                  hazard,
  input  logic                  flush,
  input  logic                  stall,
  input  logic                  stat_wr_en,
  input  logic [3:0]            status_in,
  output logic [3:0]            status,
  output logic [CMD_W-1:0]      ex_cmd,
  output logic                  ex_mem_r,
  output logic                  ex_mem_w,
  output logic                  ex_wb_en,
  output logic                  ex_b,
  output logic                  ex_s,
  output logic                  mem_r,
  output logic                  mem_w,
  output logic                  wb_en,
  output logic [PIPE_DEPTH-1:0] wb_en_vec,
  output logic [PIPE_DEPTH-1:0] mem_r_vec,
  output logic                  branch_taken
);

  typedef struct packed {
    logic [CMD_W-1:0] cmd;
    logic             mem_r;
    logic             mem_w;
    logic             wb_en;
    logic             b;
    logic             s;
  } ctrl_t;

  ctrl_t [PIPE_DEPTH-1:0] stage_q;
  ctrl_t                  dec;
  ctrl_t                  stage0_d;
  logic  [3:0]            status_q;
  logic  [3:0]            flags;
  logic                   n, z, c, v;
  logic                   cond_ok;

  always_comb begin
    dec = '0;
    unique case (mode)
      2'b00: begin
        dec.s     = s_in;
        dec.wb_en = 1'b1;
        case (opcode)
          4'b1101: dec.cmd = CMD_W'(4'b0001);
          4'b1111: dec.cmd = CMD_W'(4'b1001);
          4'b0100: dec.cmd = CMD_W'(4'b0010);
          4'b0101: dec.cmd = CMD_W'(4'b0011);
          4'b0010: dec.cmd = CMD_W'(4'b0100);
          4'b0110: dec.cmd = CMD_W'(4'b0101);
          4'b0000: dec.cmd = CMD_W'(4'b0110);
          4'b1100: dec.cmd = CMD_W'(4'b0111);
          4'b0001: dec.cmd = CMD_W'(4'b1000);
          4'b1010: begin
            dec.cmd   = CMD_W'(4'b0100);
            dec.wb_en = 1'b0;
            dec.s     = 1'b1;
          end
          4'b1000: begin
            dec.cmd   = CMD_W'(4'b0110);
            dec.wb_en = 1'b0;
            dec.s     = 1'b1;
          end
          default: dec = '0;
        endcase
      end
      2'b01: begin
        if (opcode == 4'b0100) begin
          dec.cmd   = CMD_W'(4'b0010);
          dec.mem_r = s_in;
          dec.wb_en = s_in;
          dec.mem_w = ~s_in;
        end
      end
      2'b10: dec.b = 1'b1;
      default: dec = '0;
    endcase
  end

  // A status write in the same cycle is visible to the condition check only when bypassing.
  assign flags = (STATUS_BYPASS && stat_wr_en) ? status_in : status_q;
  assign {n, z, c, v} = flags;

  always_comb begin
    cond_ok = 1'b0;
    unique case (cond)
      4'b0000: cond_ok = z;
      4'b0001: cond_ok = ~z;
      4'b0010: cond_ok = c;
      4'b0011: cond_ok = ~c;
      4'b0100: cond_ok = n;
      4'b0101: cond_ok = ~n;
      4'b0110: cond_ok = v;
      4'b0111: cond_ok = ~v;
      4'b1000: cond_ok = c & ~z;
      4'b1001: cond_ok = ~c | z;
      4'b1010: cond_ok = (n == v);
      4'b1011: cond_ok = (n != v);
      4'b1100: cond_ok = ~z & (n == v);
      4'b1101: cond_ok = z | (n != v);
      4'b1110: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  assign stage0_d = (cond_ok && id_valid && !hazard && !flush) ? dec : '0;

  // Stall freezes the pipe, but the status register keeps tracking the ALU.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q  <= '0;
      status_q <= '0;
    end else begin
      if (stat_wr_en) status_q <= status_in;
      if (!stall) begin
        stage_q[0] <= stage0_d;
        for (int i = 1; i < PIPE_DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
    end
  end

  always_comb begin
    wb_en_vec = '0;
    mem_r_vec = '0;
    for (int i = 0; i < PIPE_DEPTH; i++) begin
      wb_en_vec[i] = stage_q[i].wb_en;
      mem_r_vec[i] = stage_q[i].mem_r;
    end
  end

  assign status       = status_q;
  assign ex_cmd       = stage_q[0].cmd;
  assign ex_mem_r     = stage_q[0].mem_r;
  assign ex_mem_w     = stage_q[0].mem_w;
  assign ex_wb_en     = stage_q[0].wb_en;
  assign ex_b         = stage_q[0].b;
  assign ex_s         = stage_q[0].s;
  assign branch_taken = stage_q[0].b;
  assign mem_r        = stage_q[PIPE_DEPTH-2].mem_r;
  assign mem_w        = stage_q[PIPE_DEPTH-2].mem_w;
  assign wb_en        = stage_q[PIPE_DEPTH-1].wb_en;

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Scoreboard bench for ctrl_pipe_unit: directed vectors push hand-computed stage-0
// controls, a monitor pops them as they enter EX and follows them down the pipe.
module tb_ctrl_pipe_unit;

  localparam int PD = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [3:0] opcode = '0;
  logic [1:0] mode = '0;
  logic s_in = 1'b0;
  logic [3:0] cond = '0;
  logic id_valid = 1'b0, hazard = 1'b0, flush = 1'b0, stall = 1'b0;
  logic stat_wr_en = 1'b0;
  logic [3:0] status_in = '0;

  logic [3:0] status, ex_cmd;
  logic ex_mem_r, ex_mem_w, ex_wb_en, ex_b, ex_s, mem_r, mem_w, wb_en, branch_taken;
  logic [PD-1:0] wb_en_vec, mem_r_vec;

  logic [3:0] n_status, n_ex_cmd;
  logic n_ex_mem_r, n_ex_mem_w, n_ex_wb_en, n_ex_b, n_ex_s, n_mem_r, n_mem_w, n_wb_en, n_branch_taken;
  logic [PD-1:0] n_wb_en_vec, n_mem_r_vec;

  ctrl_pipe_unit #(.PIPE_DEPTH(PD), .STATUS_BYPASS(1'b1), .CMD_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mode(mode), .s_in(s_in), .cond(cond),
    .id_valid(id_valid), .hazard(hazard), .flush(flush), .stall(stall),
    .stat_wr_en(stat_wr_en), .status_in(status_in), .status(status),
    .ex_cmd(ex_cmd), .ex_mem_r(ex_mem_r), .ex_mem_w(ex_mem_w), .ex_wb_en(ex_wb_en),
    .ex_b(ex_b), .ex_s(ex_s), .mem_r(mem_r), .mem_w(mem_w), .wb_en(wb_en),
    .wb_en_vec(wb_en_vec), .mem_r_vec(mem_r_vec), .branch_taken(branch_taken)
  );

  ctrl_pipe_unit #(.PIPE_DEPTH(PD), .STATUS_BYPASS(1'b0), .CMD_W(4)) dutNoBypass (
    .clk(clk), .rst(rst), .opcode(opcode), .mode(mode), .s_in(s_in), .cond(cond),
    .id_valid(id_valid), .hazard(hazard), .flush(flush), .stall(stall),
    .stat_wr_en(stat_wr_en), .status_in(status_in), .status(n_status),
    .ex_cmd(n_ex_cmd), .ex_mem_r(n_ex_mem_r), .ex_mem_w(n_ex_mem_w), .ex_wb_en(n_ex_wb_en),
    .ex_b(n_ex_b), .ex_s(n_ex_s), .mem_r(n_mem_r), .mem_w(n_mem_w), .wb_en(n_wb_en),
    .wb_en_vec(n_wb_en_vec), .mem_r_vec(n_mem_r_vec), .branch_taken(n_branch_taken)
  );

  always #5 clk = ~clk;

  // Expected stage content: cmd plus {mem_r, mem_w, wb_en, b, s}.
  typedef struct packed {
    logic [3:0] cmd;
    logic [4:0] f;
  } expT;

  expT sbq[$];
  expT shadow [PD];
  logic [3:0] statusExp;
  int checks = 0;
  int errors = 0;
  bit monOn = 1'b0;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Drive one ID-stage vector; a non-stalled cycle always produces a stage-0 entry.
  task automatic applyStimulus(input logic [3:0] op, input logic [1:0] md, input logic s,
                               input logic [3:0] cd, input logic v, input logic h,
                               input logic fl, input logic st, input logic we,
                               input logic [3:0] si, input logic [3:0] ecmd,
                               input logic [4:0] ef);
    @(negedge clk);
    rst = 1'b0;
    opcode = op; mode = md; s_in = s; cond = cd;
    id_valid = v; hazard = h; flush = fl; stall = st;
    stat_wr_en = we; status_in = si;
    if (!st) sbq.push_back({ecmd, ef});
  endtask

  task automatic doReset(input int cycles, input logic st);
    @(negedge clk);
    rst = 1'b1; stall = st;
    opcode = 4'b0100; mode = 2'b00; s_in = 1'b1; cond = 4'b1110; id_valid = 1'b1;
    hazard = 1'b0; flush = 1'b0; stat_wr_en = 1'b0; status_in = 4'b0000;
    monOn = 1'b1;
    repeat (cycles) @(posedge clk);
  endtask

  // Monitor: pops an expectation on every advancing cycle and tracks it down the pipe.
  initial begin
    logic r, st, we, on;
    logic [3:0] si;
    logic [PD-1:0] wbv, mrv;
    forever begin
      @(posedge clk);
      r = rst; st = stall; we = stat_wr_en; si = status_in; on = monOn;
      #1;
      if (on) begin
        if (r) begin
          for (int i = 0; i < PD; i++) shadow[i] = '0;
          statusExp = 4'b0000;
        end else begin
          if (we) statusExp = si;
          if (!st) begin
            for (int i = PD - 1; i > 0; i--) shadow[i] = shadow[i-1];
            if (sbq.size() == 0) begin
              checks++; errors++;
              $display("[TB] FAIL sb_underflow at %0t: got empty queue expected an entry", $time);
              shadow[0] = '0;
            end else begin
              shadow[0] = sbq.pop_front();
            end
          end
        end
        for (int i = 0; i < PD; i++) begin
          wbv[i] = shadow[i].f[2];
          mrv[i] = shadow[i].f[4];
        end
        checkOutput("ex_ctrl", {7'd0, ex_cmd, ex_mem_r, ex_mem_w, ex_wb_en, ex_b, ex_s},
                    {7'd0, shadow[0]});
        checkOutput("branch_taken", {15'd0, branch_taken}, {15'd0, shadow[0].f[1]});
        checkOutput("mem_rw", {14'd0, mem_r, mem_w}, {14'd0, shadow[PD-2].f[4:3]});
        checkOutput("wb_en", {15'd0, wb_en}, {15'd0, shadow[PD-1].f[2]});
        checkOutput("wb_en_vec", 16'(wb_en_vec), 16'(wbv));
        checkOutput("mem_r_vec", 16'(mem_r_vec), 16'(mrv));
        checkOutput("status", {12'd0, status}, {12'd0, statusExp});
      end
    end
  end

  initial begin
    // Reset with an ADD applied, then ADD and its walk through the pipe.
    doReset(2, 1'b0);
    applyStimulus(4'b0100, 2'b00, 1'b1, 4'b1110, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'b0010, 5'b00101);
    repeat (3) applyStimulus(4'b0000, 2'b00, 1'b0, 4'b1110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'b0000, 5'b00000);

    // LDR then CMP with s_in=0.
    applyStimulus(4'b0100, 2'b01, 1'b1, 4'b1110, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'b0010, 5'b10100);
    applyStimulus(4'b1010, 2'b00, 1'b0, 4'b1110, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'b0100, 5'b00001);

    // ADDEQ while Z is being written: bypass executes, registered-only path does not.
    applyStimulus(4'b0100, 2'b00, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0100, 4'b0010, 5'b00100);
    @(posedge clk); #1;
    checkOutput("nobypass_ex_wb", {15'd0, n_ex_wb_en}, 16'd0);
    checkOutput("nobypass_status", {12'd0, n_status}, 16'h0004);
    applyStimulus(4'b0100, 2'b00, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'b0000, 5'b00000);
    applyStimulus(4'b0100, 2'b00, 1'b0, 4'b1010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'b0010, 5'b00100);
    applyStimulus(4'b0101, 2'b00, 1'b0, 4'b1000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'b0000, 5'b00000);

    // ADD, SUB under hazard, ORR.
    applyStimulus(4'b0100, 2'b00, 1'b1, 4'b1110, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'b0010, 5'b00101);
    applyStimulus(4'b0010, 2'b00, 1'b0, 4'b1110, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'b0000, 5'b00000);
    applyStimulus(4'b1100, 2'b00, 1'b0, 4'b1110, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'b0111, 5'b00100);

    // Stall with flush for 3 cycles (status still writes), then one bubble, then reset under stall.
    applyStimulus(4'b0010, 2'b00, 1'b1, 4'b1110, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'b0100, 5'b00101);
    applyStimulus(4'b0100, 2'b00, 1'b1, 4'b1110, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'b0000, 5'b00000);
    applyStimulus(4'b0100, 2'b00, 1'b1, 4'b1110, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0010, 4'b0000, 5'b00000);
    applyStimulus(4'b0100, 2'b00, 1'b1, 4'b1110, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'b0000, 5'b00000);
    applyStimulus(4'b0100, 2'b00, 1'b1, 4'b1110, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'b0000, 5'b00000);
    applyStimulus(4'b0100, 2'b00, 1'b1, 4'b1110, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'b0010, 5'b00101);
    doReset(1, 1'b1);

    // Undefined, branch, never-condition and the remaining decodes.
    applyStimulus(4'b0100, 2'b11, 1'b1, 4'b1110, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'b0000, 5'b00000);
    applyStimulus(4'b0000, 2'b01, 1'b1, 4'b1110, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'b0000, 5'b00000);
    applyStimulus(4'b0000, 2'b10, 1'b0, 4'b1110, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'b0000, 5'b00010);
    applyStimulus(4'b0100, 2'b00, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'b0000, 5'b00000);
    applyStimulus(4'b1111, 2'b00, 1'b1, 4'b1110, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'b1001, 5'b00101);
    applyStimulus(4'b0100, 2'b01, 1'b0, 4'b1110, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'b0010, 5'b01000);
    applyStimulus(4'b1000, 2'b00, 1'b0, 4'b1110, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'b0110, 5'b00001);
    applyStimulus(4'b0001, 2'b00, 1'b0, 4'b1110, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'b1000, 5'b00100);
    applyStimulus(4'b0110, 2'b00, 1'b1, 4'b1110, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'b0101, 5'b00101);
    repeat (4) applyStimulus(4'b0000, 2'b00, 1'b0, 4'b1110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'b0000, 5'b00000);

    @(posedge clk); #2;
    checkOutput("sb_drained", 16'(sbq.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe_unit.md
Name: ctrl_pipe_unit

Overview:
- Parametrised successor to the combinational ID-stage control decoder.
- Decodes opcode, mode and S into execute, memory and writeback controls, then gates them by the ARM condition field against an internal NZCV status register.
- Carries the controls through a PIPE_DEPTH-stage control pipeline (EX, MEM, ..., WB) with freeze, flush and global-stall handling.
- Sits between the ID stage and the EX/MEM/WB datapath registers, and feeds the hazard unit.

Parameters:
- PIPE_DEPTH, 3, number of registered control stages after ID. Stage 0 is EX, stage PIPE_DEPTH-2 is MEM, stage PIPE_DEPTH-1 is WB. Legal range is 3..8.
- STATUS_BYPASS, 1, when 1 the condition check uses status_in while stat_wr_en is high in the same cycle. When 0 it always uses the registered status.
- CMD_W, 4, width of the EXE_CMD field.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  4  instruction opcode
- mode  in  2  instruction mode (00 data, 01 memory, 10 branch)
- s_in  in  1  instruction S bit
- cond  in  4  instruction condition field
- id_valid  in  1  ID holds a real instruction
- hazard  in  1  insert a bubble into stage 0 (from the hazard unit)
- flush  in  1  branch flush, kills the ID instruction
- stall  in  1  global stall (memory not ready), freezes every stage
- stat_wr_en  in  1  write status register
- status_in  in  4  NZCV from the ALU
- status  out  4  registered NZCV
- ex_cmd  out  CMD_W  stage-0 EXE_CMD
- ex_mem_r, ex_mem_w, ex_wb_en, ex_b, ex_s  out  1 each  stage-0 controls
- mem_r, mem_w  out  1 each  MEM-stage controls
- wb_en  out  1  WB-stage write enable
- wb_en_vec  out  PIPE_DEPTH  wb_en of every stage, bit i = stage i
- mem_r_vec  out  PIPE_DEPTH  mem_r of every stage, for load-use detection
- branch_taken  out  1  equal to ex_b

Behaviour:
- Decode for mode 00 gives EXE_CMD and WB_EN as follows:
  - MOV 1101: cmd 0001, WB=1
  - MVN 1111: cmd 1001, WB=1
  - ADD 0100: cmd 0010, WB=1
  - ADC 0101: cmd 0011, WB=1
  - SUB 0010: cmd 0100, WB=1
  - SBC 0110: cmd 0101, WB=1
  - AND 0000: cmd 0110, WB=1
  - ORR 1100: cmd 0111, WB=1
  - EOR 0001: cmd 1000, WB=1
  - CMP 1010: cmd 0100, WB=0
  - TST 1000: cmd 0110, WB=0
- S output for mode 00 is s_in, except CMP and TST, which force S=1.
- Decode for mode 01 applies only with opcode 0100, and always gives cmd 0010 with S=0:
  - s_in=1 is LDR: MEM_R=1, WB=1.
  - s_in=0 is STR: MEM_W=1, WB=0.
- Decode for mode 10 is B: B=1, all other controls 0, cmd 0000.
- Any other mode or opcode combination decodes to all-zero (NOP).
- Condition check against NZCV:
  - 0000 Z
  - 0001 !Z
  - 0010 C
  - 0011 !C
  - 0100 N
  - 0101 !N
  - 0110 V
  - 0111 !V
  - 1000 C&!Z
  - 1001 !C|Z
  - 1010 N==V
  - 1011 N!=V
  - 1100 !Z&(N==V)
  - 1101 Z|(N!=V)
  - 1110 always
  - 1111 never
- An instruction enters stage 0 with all controls zeroed when any of these holds: condition false, id_valid=0, hazard=1, flush=1.
- Stage update each cycle with rst=0:
  - If stall=1, all stages and status hold, except that status still follows stat_wr_en.
  - Otherwise stage 0 loads the gated decode and stage i loads stage i-1 for i from 1 to PIPE_DEPTH-1.
- Simultaneous events:
  - hazard or flush coinciding with stall: stall wins, nothing moves.
  - The bubble is inserted on the first cycle with stall=0 if hazard or flush is still asserted.
- Status register: loads status_in on stat_wr_en=1, otherwise holds.
- Status bypass: with STATUS_BYPASS=1 and stat_wr_en=1, the cond check in that same cycle uses status_in.
- Latency: ID to ex_* is 1 cycle, to mem_r/mem_w is PIPE_DEPTH-1 cycles, to wb_en is PIPE_DEPTH cycles.
- Reset: every stage register and status clear to 0 on rising edge with rst=1, so every output is 0. Reset mid-operation discards all in-flight controls in that cycle.
- Reset priority: rst overrides stall.

Test Plan:
1. Reset with PIPE_DEPTH=3: rst=1 for 2 cycles with ADD applied -> all outputs 0. Release, apply ADD (opcode 0100, mode 00, cond 1110, s_in=1) -> ex_cmd=0010, ex_wb_en=1, ex_s=1 at cycle 1, wb_en=1 at cycle 3, wb_en_vec walks 001, 010, 100.
2. Loads and compares: LDR (mode 01, opcode 0100, s_in=1) -> ex_mem_r=1, ex_wb_en=1, mem_r_vec bit 1 set on the next cycle. CMP with s_in=0 -> ex_s=1, ex_wb_en=0, ex_cmd=0100.
3. Condition with bypass: status=0000, stat_wr_en=1 with status_in=0100 (Z), same cycle as ADDEQ -> executes (ex_wb_en=1). With STATUS_BYPASS=0 -> NOP, status=0100 on the next cycle.
4. Hazard bubble: a stream ADD, SUB, ORR with hazard=1 during SUB -> stage 0 is zero for that cycle while ADD advances to stage 1, and ORR follows normally.
5. Stall against flush: stall=1 for 3 cycles with flush=1 -> all stages frozen, then one bubble on release. Assert rst while stall=1 -> all stages 0 on the next cycle.
6. Undefined and branch decode: mode 11 and mode 01 with opcode 0000 -> all-zero controls. B (mode 10, cond 1110) -> branch_taken=1 for exactly 1 cycle. cond 1111 -> no output.
